sccb_cfg_seq: RTL and testbench
===============================

Name: sccb_cfg_seq

Overview:
- Register-table sequencer that sits directly upstream of the SCCB write engine and drives the OV7670 configuration.
- Once the power-up delay has elapsed, it walks a ROM of {register address, data} pairs and presents one pair per SCCB write transaction using a write_en / wr_done handshake.
- It applies inter-write gaps and a long settle delay after a camera soft reset.
- It detects a hung transaction with a watchdog and retries it, then reports completion and errors to the capture/top level.

Parameters:
- REG_NUM, 64, number of table entries (1..255).
- IDX_W, 8, width of the table index.
- GAP_CYC, 1000, idle cycles between writes (20 us at 50 MHz).
- RESET_WAIT, 50000, idle cycles after a soft-reset entry (1 ms).
- TIMEOUT_CYC, 100000, maximum cycles in WRITE without wr_done.
- MAX_RETRY, 3, attempts per entry before the entry is skipped.

Ports:
- sclk  in  1  system clock, 50 MHz.
- rst  in  1  synchronous, active-high reset.
- init_en  in  1  level; power-up delay from the SCCB engine has elapsed.
- cfg_start  in  1  one-cycle pulse; re-run the whole table (accepted only in DONE).
- wr_done  in  1  one-cycle pulse from the SCCB engine at the end of STOP.
- write_en  out  1  level request to the SCCB engine; held until wr_done.
- sccb_addr  out  8  register address; stable while write_en is high.
- sccb_data  out  8  register data; stable while write_en is high.
- cfg_busy  out  1  high in every state except WAIT_INIT and DONE.
- cfg_done  out  1  high in DONE.
- cfg_err  out  1  sticky; at least one entry was skipped.
- err_cnt  out  4  timeouts counted; saturates at 15.
- reg_idx  out  IDX_W  index of the current entry.

Behaviour:
- Reset values: write_en=0, sccb_addr=0, sccb_data=0, cfg_busy=0, cfg_done=0, cfg_err=0, err_cnt=0, reg_idx=0; state=WAIT_INIT.
- Reset is honoured in any state. Asserting rst mid-transaction drops write_en at the same edge.
- States: WAIT_INIT, LOAD, WRITE, GAP, DONE.

State transitions:
- WAIT_INIT: stay while init_en=0. init_en=1 -> LOAD.
- LOAD (1 cycle):
  - sccb_addr/sccb_data <= ROM[reg_idx].
  - Clear the watchdog counter; -> WRITE.
  - write_en rises on the edge that enters WRITE, so data is valid 1 cycle before or coincident with the request.
- WRITE: write_en=1.
  - On wr_done: write_en<=0 on the same edge, retry_cnt<=0.
    - gap length <= RESET_WAIT if (sccb_addr==8'h12 and sccb_data[7]==1), else GAP_CYC.
    - -> GAP.
  - On watchdog reaching TIMEOUT_CYC-1 with no wr_done:
    - write_en<=0; err_cnt saturating +1; retry_cnt+1.
    - gap=GAP_CYC; -> GAP, marked as a retry.
  - If wr_done and the timeout coincide, wr_done wins.
- GAP: count down the gap length. At zero:
  - If marked retry and retry_cnt<MAX_RETRY: -> LOAD, same reg_idx.
  - If marked retry and retry_cnt==MAX_RETRY: cfg_err<=1, retry_cnt<=0, then advance.
  - Otherwise advance.
  - Advance rule: if reg_idx==REG_NUM-1 -> DONE (reg_idx holds); else reg_idx+1 -> LOAD.
- DONE: cfg_done=1.
  - cfg_start clears cfg_done, cfg_err, err_cnt, reg_idx and retry_cnt; -> LOAD. init_en is not re-checked.

Ignored inputs and boundary cases:
- cfg_start in any state other than DONE is ignored.
- wr_done outside WRITE is ignored.
- init_en falling after WAIT_INIT is ignored.
- REG_NUM=1: one write, then DONE.

Widths:
- Gap and watchdog counters are 17 bits. RESET_WAIT and TIMEOUT_CYC must be below 2^17; this is checked by an elaboration assertion.
- retry_cnt is 2 bits; MAX_RETRY is 1..3.

Decomposition:
- Package sccb_cfg_pkg:
  - State encoding (one-hot, 5 bits).
  - Constant COM7_ADDR=8'h12 and soft-reset bit index 7.
  - Default timing constants.
- Sub-module ov7670_reg_rom: combinational lookup from IDX_W index to 16-bit {addr,data}.
  - Entry 0 is {8'h12,8'h80}.
  - Entries beyond the populated table return {8'hFF,8'hFF}.
  - The sequencer treats 8'hFF as an ordinary write.

Test Plan:
- Power-up: hold init_en=0 for 500 cycles, then raise it. Required response: write_en stays 0 while init_en is low; write_en rises 2 cycles after init_en with sccb_addr=8'h12, sccb_data=8'h80.
- Normal sequence, REG_NUM=4, wr_done returned 300 cycles after each write_en rise. Required response:
  - 4 write_en pulses with ROM values in order.
  - Spacing: RESET_WAIT after entry 0, GAP_CYC after the others.
  - cfg_done=1 and reg_idx=3 at the end; cfg_err=0.
- Single timeout, TIMEOUT_CYC=200, no wr_done on entry 1 first attempt, acked on the second. Required response: write_en drops after 200 cycles; err_cnt=1; entry 1 is re-sent with the same addr/data; cfg_err=0 at DONE.
- Permanent hang on entry 2, MAX_RETRY=3. Required response: 3 attempts; err_cnt=3; cfg_err=1; sequence continues to entry 3 and reaches DONE.
- wr_done and the watchdog fire in the same cycle. Required response: treated as success; err_cnt unchanged.
- rst pulsed mid-WRITE, then cfg_start pulsed in DONE. Required response:
  - After rst: all outputs return to reset values on the next edge, and the sequence restarts from index 0 once init_en is high.
  - cfg_start in DONE reruns the table and clears err_cnt.
  - cfg_start pulsed while busy has no effect.

Source files
------------

// File: rtl/sccb_cfg_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sccb_cfg_pkg
// Brief    : Shared types and constants for the OV7670 register sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package sccb_cfg_pkg;

    // One-hot state encoding of the table walker
    typedef enum logic [4:0] {
        ST_WAIT_INIT = 5'b00001,
        ST_LOAD      = 5'b00010,
        ST_WRITE     = 5'b00100,
        ST_GAP       = 5'b01000,
        ST_DONE      = 5'b10000
    } state_t;

    // COM7 holds the soft-reset bit; writing it needs a long settle time
    localparam logic [7:0] COM7_ADDR      = 8'h12;
    localparam int         COM7_RESET_BIT = 7;

    // Default timing at 50 MHz
    localparam int DEF_GAP_CYC     = 1000;
    localparam int DEF_RESET_WAIT  = 50000;
    localparam int DEF_TIMEOUT_CYC = 100000;
    localparam int DEF_MAX_RETRY   = 3;

    // Width of the gap and watchdog counters
    localparam int CNT_W = 17;

    // True when a write to {addr,data} triggers a camera soft reset
    function automatic logic is_soft_reset(input logic [7:0] addr, input logic [7:0] data);
        return (addr == COM7_ADDR) && data[COM7_RESET_BIT];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sccb_cfg_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : sccb_cfg_seq_if
// Brief    : Request/acknowledge bus between the sequencer and SCCB engine.
// Revision : 1.0 - initial release
// ============================================================================
interface sccb_cfg_seq_if;
    logic       write_en;
    logic       wr_done;
    logic [7:0] sccb_addr;
    logic [7:0] sccb_data;

    // Sequencer side: issues requests, receives completion
    modport master (
        output write_en,
        output sccb_addr,
        output sccb_data,
        input  wr_done
    );

    // SCCB engine side
    modport slave (
        input  write_en,
        input  sccb_addr,
        input  sccb_data,
        output wr_done
    );
endinterface
`default_nettype wire

// File: rtl/sccb_cfg_seq_rom.sv
`default_nettype none
// ============================================================================
// Module   : ov7670_reg_rom
// Brief    : Combinational OV7670 configuration table, {addr,data} per entry.
//            Unpopulated entries read back as {8'hFF,8'hFF}.
// Revision : 1.0 - initial release
// ============================================================================
module ov7670_reg_rom #(
    parameter int IDX_W = 8
) (
    input  wire logic [IDX_W-1:0] idx,
    output logic      [15:0]      entry
);

    // Table lookup; entry 0 must be the COM7 soft reset
    always_comb begin
        entry = 16'hFFFF;
        case (idx)
            IDX_W'(0):  entry = 16'h1280;  // COM7: soft reset
            IDX_W'(1):  entry = 16'h1101;  // CLKRC: prescaler /2
            IDX_W'(2):  entry = 16'h1204;  // COM7: RGB output
            IDX_W'(3):  entry = 16'h0C00;  // COM3: defaults
            IDX_W'(4):  entry = 16'h3E00;  // COM14: no PCLK scaling
            IDX_W'(5):  entry = 16'h703A;  // SCALING_XSC
            IDX_W'(6):  entry = 16'h7135;  // SCALING_YSC
            IDX_W'(7):  entry = 16'h40D0;  // COM15: RGB565 full range
            IDX_W'(8):  entry = 16'h8C00;  // RGB444 off
            IDX_W'(9):  entry = 16'h3A04;  // TSLB
            default:    entry = 16'hFFFF;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sccb_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : sccb_cfg_seq
// Brief    : Walks the OV7670 register table and hands one {addr,data} pair
//            per transaction to the SCCB write engine, with inter-write gaps,
//            soft-reset settle time, watchdog retry and status reporting.
// Revision : 1.0 - initial release
// ============================================================================
module sccb_cfg_seq
    import sccb_cfg_pkg::*;
#(
    parameter int REG_NUM     = 64,
    parameter int IDX_W       = 8,
    parameter int GAP_CYC     = DEF_GAP_CYC,
    parameter int RESET_WAIT  = DEF_RESET_WAIT,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int MAX_RETRY   = DEF_MAX_RETRY
) (
    input  wire logic             sclk,
    input  wire logic             rst,
    input  wire logic             init_en,
    input  wire logic             cfg_start,
    sccb_cfg_seq_if.master        bus,
    output logic                  cfg_busy,
    output logic                  cfg_done,
    output logic                  cfg_err,
    output logic      [3:0]       err_cnt,
    output logic      [IDX_W-1:0] reg_idx
);

    // Counters hold "length - 1" so that GAP lasts exactly the gap length
    localparam logic [CNT_W-1:0] C_GAP_LOAD   = CNT_W'(GAP_CYC - 1);
    localparam logic [CNT_W-1:0] C_RST_LOAD   = CNT_W'(RESET_WAIT - 1);
    localparam logic [CNT_W-1:0] C_WD_LAST    = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [1:0]       C_MAX_RETRY  = 2'(MAX_RETRY);
    localparam logic [IDX_W-1:0] C_LAST_IDX   = IDX_W'(REG_NUM - 1);

    // Reject parameter sets the counters cannot represent
    if (RESET_WAIT >= 2**CNT_W || TIMEOUT_CYC >= 2**CNT_W || GAP_CYC >= 2**CNT_W ||
        GAP_CYC < 1 || RESET_WAIT < 1 || TIMEOUT_CYC < 1 ||
        MAX_RETRY < 1 || MAX_RETRY > 3 ||
        REG_NUM < 1 || REG_NUM > 255 || REG_NUM > 2**IDX_W) begin : g_param_check
        $error("sccb_cfg_seq: parameter out of range");
    end

    state_t             r_state;
    state_t             w_next;
    logic [7:0]         r_addr;
    logic [7:0]         r_data;
    logic [CNT_W-1:0]   r_wd_cnt;
    logic [CNT_W-1:0]   r_gap_cnt;
    logic [1:0]         r_retry_cnt;
    logic               r_retry;
    logic               r_cfg_err;
    logic [3:0]         r_err_cnt;
    logic [IDX_W-1:0]   r_reg_idx;
    logic [15:0]        w_rom;
    logic               w_timeout;
    logic               w_gap_end;
    logic               w_resend;
    logic               w_last;

    ov7670_reg_rom #(
        .IDX_W (IDX_W)
    ) u_rom (
        .idx   (r_reg_idx),
        .entry (w_rom)
    );

    assign w_timeout = (r_wd_cnt == C_WD_LAST);
    assign w_gap_end = (r_gap_cnt == '0);
    assign w_resend  = r_retry && (r_retry_cnt < C_MAX_RETRY);
    assign w_last    = (r_reg_idx == C_LAST_IDX);

    // State register
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_state <= ST_WAIT_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; wr_done takes priority over a coincident timeout
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_WAIT_INIT: if (init_en) w_next = ST_LOAD;
            ST_LOAD:      w_next = ST_WRITE;
            ST_WRITE:     if (bus.wr_done || w_timeout) w_next = ST_GAP;
            ST_GAP: begin
                if (w_gap_end) begin
                    if (w_resend)    w_next = ST_LOAD;
                    else if (w_last) w_next = ST_DONE;
                    else             w_next = ST_LOAD;
                end
            end
            ST_DONE:      if (cfg_start) w_next = ST_LOAD;
            default:      w_next = ST_WAIT_INIT;
        endcase
    end

    // Datapath: pair latch, watchdog, gap timer, retry and error bookkeeping
    always_ff @(posedge sclk) begin
        if (rst) begin
            r_addr      <= '0;
            r_data      <= '0;
            r_wd_cnt    <= '0;
            r_gap_cnt   <= '0;
            r_retry_cnt <= '0;
            r_retry     <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_err_cnt   <= '0;
            r_reg_idx   <= '0;
        end else begin
            case (r_state)
                ST_LOAD: begin
                    r_addr   <= w_rom[15:8];
                    r_data   <= w_rom[7:0];
                    r_wd_cnt <= '0;
                end
                ST_WRITE: begin
                    if (bus.wr_done) begin
                        r_retry_cnt <= '0;
                        r_retry     <= 1'b0;
                        r_gap_cnt   <= is_soft_reset(r_addr, r_data) ? C_RST_LOAD : C_GAP_LOAD;
                    end else if (w_timeout) begin
                        if (r_err_cnt != 4'hF) r_err_cnt <= r_err_cnt + 4'd1;
                        r_retry_cnt <= r_retry_cnt + 2'd1;
                        r_retry     <= 1'b1;
                        r_gap_cnt   <= C_GAP_LOAD;
                    end else begin
                        r_wd_cnt <= r_wd_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    if (!w_gap_end) begin
                        r_gap_cnt <= r_gap_cnt - CNT_W'(1);
                    end else if (!w_resend) begin
                        // Retries exhausted: skip this entry and flag it
                        if (r_retry) begin
                            r_cfg_err   <= 1'b1;
                            r_retry_cnt <= '0;
                            r_retry     <= 1'b0;
                        end
                        if (!w_last) r_reg_idx <= r_reg_idx + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (cfg_start) begin
                        r_cfg_err   <= 1'b0;
                        r_err_cnt   <= '0;
                        r_reg_idx   <= '0;
                        r_retry_cnt <= '0;
                        r_retry     <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // write_en follows the WRITE state so it rises and falls on the state edges
    assign bus.write_en  = (r_state == ST_WRITE);
    assign bus.sccb_addr = r_addr;
    assign bus.sccb_data = r_data;
    assign cfg_busy      = (r_state != ST_WAIT_INIT) && (r_state != ST_DONE);
    assign cfg_done      = (r_state == ST_DONE);
    assign cfg_err       = r_cfg_err;
    assign err_cnt       = r_err_cnt;
    assign reg_idx       = r_reg_idx;

endmodule
`default_nettype wire

// File: tb/tb_sccb_cfg_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sccb_cfg_seq
// Brief    : Directed self-checking bench for sccb_cfg_seq with a scoreboard
//            of expected {addr,data} requests.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sccb_cfg_seq;

    localparam int REG_NUM     = 4;
    localparam int IDX_W       = 8;
    localparam int GAP_CYC     = 20;
    localparam int RESET_WAIT  = 100;
    localparam int TIMEOUT_CYC = 200;
    localparam int MAX_RETRY   = 3;

    logic             sclk = 1'b0;
    logic             rst;
    logic             init_en;
    logic             cfg_start;
    logic             cfg_busy;
    logic             cfg_done;
    logic             cfg_err;
    logic [3:0]       err_cnt;
    logic [IDX_W-1:0] reg_idx;

    sccb_cfg_seq_if bus ();

    sccb_cfg_seq #(
        .REG_NUM     (REG_NUM),
        .IDX_W       (IDX_W),
        .GAP_CYC     (GAP_CYC),
        .RESET_WAIT  (RESET_WAIT),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .MAX_RETRY   (MAX_RETRY)
    ) dut (
        .sclk      (sclk),
        .rst       (rst),
        .init_en   (init_en),
        .cfg_start (cfg_start),
        .bus       (bus.master),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err),
        .err_cnt   (err_cnt),
        .reg_idx   (reg_idx)
    );

    always #5 sclk = ~sclk;

    int total = 0;
    int bad   = 0;

    // Expected table contents for the first four entries
    logic [15:0] rom_exp [0:3] = '{16'h1280, 16'h1101, 16'h1204, 16'h0C00};
    logic [15:0] exp_q [$];

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check(bus.write_en,  0, {tag, "_write_en"});
        check(bus.sccb_addr, 0, {tag, "_addr"});
        check(bus.sccb_data, 0, {tag, "_data"});
        check(cfg_busy,      0, {tag, "_busy"});
        check(cfg_done,      0, {tag, "_done"});
        check(cfg_err,       0, {tag, "_err"});
        check(err_cnt,       0, {tag, "_err_cnt"});
        check(reg_idx,       0, {tag, "_reg_idx"});
    endtask

    // Wait for write_en high; check latency and pair against the scoreboard
    task automatic expect_req(input int exp_wait, input string tag);
        int          n    = 0;
        logic        seen = 1'b0;
        logic [15:0] exp;
        while (!seen && n < 2000) begin
            @(negedge sclk);
            bus.wr_done = 1'b0;
            cfg_start   = 1'b0;
            n++;
            seen = bus.write_en;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check(seen, 1, {tag, "_seen"});
        check(n, exp_wait, {tag, "_wait"});
        check({bus.sccb_addr, bus.sccb_data}, exp, {tag, "_pair"});
    endtask

    task automatic ack_after(input int d);
        repeat (d) @(negedge sclk);
        bus.wr_done = 1'b1;
    endtask

    // Count cycles until write_en drops without an acknowledge
    task automatic expect_timeout(input string tag);
        int   n    = 0;
        logic fell = 1'b0;
        while (!fell && n < TIMEOUT_CYC + 50) begin
            @(negedge sclk);
            n++;
            fell = !bus.write_en;
        end
        check(n, TIMEOUT_CYC, {tag, "_timeout_len"});
    endtask

    task automatic wait_done(input int exp_wait, input string tag);
        int   n    = 0;
        logic seen = 1'b0;
        while (!seen && n < 2000) begin
            @(negedge sclk);
            bus.wr_done = 1'b0;
            n++;
            seen = cfg_done;
        end
        check(n, exp_wait, {tag, "_done_wait"});
    endtask

    // Pulse cfg_start in DONE and confirm the status is cleared
    task automatic start_run(input string tag);
        @(negedge sclk);
        cfg_start = 1'b1;
        @(negedge sclk);
        cfg_start = 1'b0;
        check(cfg_done, 0, {tag, "_done_clr"});
        check(cfg_err,  0, {tag, "_err_clr"});
        check(err_cnt,  0, {tag, "_err_cnt_clr"});
        check(reg_idx,  0, {tag, "_idx_clr"});
        check(cfg_busy, 1, {tag, "_busy"});
    endtask

    initial begin
        logic idle_bad;
        rst         = 1'b1;
        init_en     = 1'b0;
        cfg_start   = 1'b0;
        bus.wr_done = 1'b0;
        repeat (3) @(negedge sclk);
        check_reset_outputs("rst");
        rst = 1'b0;

        // Power-up: nothing happens while init_en is low, stray cfg_start ignored
        idle_bad = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge sclk);
            cfg_start = (i == 250);
            idle_bad  = idle_bad | bus.write_en | cfg_busy;
        end
        check(idle_bad, 0, "idle_no_write");
        cfg_start = 1'b0;
        init_en   = 1'b1;

        // Run 1: every entry acknowledged
        for (int i = 0; i < 4; i++) exp_q.push_back(rom_exp[i]);
        expect_req(2, "r1e0");
        ack_after(50);
        expect_req(RESET_WAIT + 2, "r1e1");
        ack_after(50);
        expect_req(GAP_CYC + 2, "r1e2");
        ack_after(50);
        expect_req(GAP_CYC + 2, "r1e3");
        ack_after(50);
        wait_done(GAP_CYC + 1, "r1");
        check(reg_idx,  3, "r1_idx");
        check(cfg_err,  0, "r1_err");
        check(err_cnt,  0, "r1_err_cnt");
        check(cfg_busy, 0, "r1_busy");
        // Stray wr_done in DONE is ignored
        @(negedge sclk);
        bus.wr_done = 1'b1;
        @(negedge sclk);
        bus.wr_done = 1'b0;
        @(negedge sclk);
        check(cfg_done,     1, "r1_stray_ack_done");
        check(bus.write_en, 0, "r1_stray_ack_we");

        // Run 2: one timeout on entry 1, then acknowledged
        start_run("r2");
        exp_q.push_back(rom_exp[0]);
        exp_q.push_back(rom_exp[1]);
        exp_q.push_back(rom_exp[1]);
        exp_q.push_back(rom_exp[2]);
        exp_q.push_back(rom_exp[3]);
        expect_req(1, "r2e0");
        ack_after(50);
        expect_req(RESET_WAIT + 2, "r2e1a");
        expect_timeout("r2e1a");
        check(err_cnt, 1, "r2_err_cnt_after_to");
        expect_req(GAP_CYC + 1, "r2e1b");
        ack_after(50);
        expect_req(GAP_CYC + 2, "r2e2");
        ack_after(50);
        expect_req(GAP_CYC + 2, "r2e3");
        ack_after(50);
        wait_done(GAP_CYC + 1, "r2");
        check(cfg_err, 0, "r2_err");
        check(err_cnt, 1, "r2_err_cnt");

        // Run 3: entry 2 never acknowledged, skipped after MAX_RETRY attempts
        start_run("r3");
        exp_q.push_back(rom_exp[0]);
        exp_q.push_back(rom_exp[1]);
        for (int i = 0; i < MAX_RETRY; i++) exp_q.push_back(rom_exp[2]);
        exp_q.push_back(rom_exp[3]);
        expect_req(1, "r3e0");
        ack_after(50);
        expect_req(RESET_WAIT + 2, "r3e1");
        ack_after(50);
        expect_req(GAP_CYC + 2, "r3e2a");
        expect_timeout("r3e2a");
        expect_req(GAP_CYC + 1, "r3e2b");
        expect_timeout("r3e2b");
        check(cfg_err, 0, "r3_err_mid");
        expect_req(GAP_CYC + 1, "r3e2c");
        expect_timeout("r3e2c");
        expect_req(GAP_CYC + 1, "r3e3");
        ack_after(50);
        wait_done(GAP_CYC + 1, "r3");
        check(err_cnt, 3, "r3_err_cnt");
        check(cfg_err, 1, "r3_err");
        check(reg_idx, 3, "r3_idx");

        // Run 4: wr_done coincides with the watchdog on entry 1
        start_run("r4");
        exp_q.push_back(rom_exp[0]);
        exp_q.push_back(rom_exp[1]);
        exp_q.push_back(rom_exp[2]);
        expect_req(1, "r4e0");
        ack_after(50);
        expect_req(RESET_WAIT + 2, "r4e1");
        ack_after(TIMEOUT_CYC - 1);
        expect_req(GAP_CYC + 2, "r4e2");
        check(err_cnt, 0, "r4_err_cnt");
        check(cfg_err, 0, "r4_err");

        // cfg_start while busy is ignored, then reset mid-WRITE
        repeat (10) @(negedge sclk);
        cfg_start = 1'b1;
        @(negedge sclk);
        cfg_start = 1'b0;
        check(reg_idx,      2, "busy_start_idx");
        check(bus.write_en, 1, "busy_start_we");
        check(cfg_busy,     1, "busy_start_busy");
        rst     = 1'b1;
        init_en = 1'b0;
        @(negedge sclk);
        check_reset_outputs("midrst");
        rst = 1'b0;
        idle_bad = 1'b0;
        repeat (20) begin
            @(negedge sclk);
            idle_bad = idle_bad | bus.write_en;
        end
        check(idle_bad, 0, "midrst_idle");
        init_en = 1'b1;

        // Run 5: full restart from index 0
        exp_q.delete();
        for (int i = 0; i < 4; i++) exp_q.push_back(rom_exp[i]);
        expect_req(2, "r5e0");
        ack_after(50);
        expect_req(RESET_WAIT + 2, "r5e1");
        ack_after(50);
        expect_req(GAP_CYC + 2, "r5e2");
        ack_after(50);
        expect_req(GAP_CYC + 2, "r5e3");
        ack_after(50);
        wait_done(GAP_CYC + 1, "r5");
        check(reg_idx, 3, "r5_idx");
        check(err_cnt, 0, "r5_err_cnt");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
